// File: rtl/systolic_seq_pkg.sv
// Purpose: shared types and sizing for the systolic array sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_seq_pkg;

  localparam int N         = 32;
  localparam int KW        = 9;
  localparam int DRAIN_CYC = 2 * N - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Skew (n-1) plus propagation (n-1) steps that follow the k operand beats.
  function automatic int drain_of(input int n);
    return 2 * n - 2;
  endfunction

  // Step counter must hold k_len_max + drain without wrapping.
  function automatic int cnt_width(input int n, input int kw);
    return $clog2((1 << kw) + 2 * n);
  endfunction

endpackage

// File: rtl/systolic_seq_skew_mask_gen.sv
// Purpose: diagonal skew mask; row/col i is live for steps i .. i+klen-1.
// Latency: combinational.
// Backpressure: run_en low (stalled or not running) forces the mask to zero.
// Ports: cnt (current step), klen (latched inner length), run_en, row_valid[N].
module skew_mask_gen #(
  parameter int N  = 32,
  parameter int KW = 9,
  parameter int CW = 10
) (
  input  logic [CW-1:0] cnt,
  input  logic [KW-1:0] klen,
  input  logic          run_en,
  output logic [N-1:0]  row_valid
);

  always_comb begin
    row_valid = '0;
    for (int i = 0; i < N; i++) begin
      row_valid[i] = run_en && (cnt >= CW'(i)) && (cnt < CW'(i) + CW'(klen));
    end
  end

endmodule

// File: rtl/systolic_seq.sv
// Purpose: sequences one N x N tile multiply: clear, k+drain array steps, done pulse.
// Latency: done arrives k_len + 2N cycles after start is accepted (plus one per stalled step).
// Backpressure: stall freezes the step counter and drops pe_en, read strobes and row_valid.
// Ports: clk, rst_n, start/k_len (request), stall (operand buffers not ready),
//        busy, a_rd_en/b_rd_en/rd_addr (operand reads), pe_clear/pe_en/row_valid (array control), done.
module systolic_seq #(
  parameter int N  = systolic_seq_pkg::N,
  parameter int KW = systolic_seq_pkg::KW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          stall,
  output logic          busy,
  output logic          a_rd_en,
  output logic          b_rd_en,
  output logic [KW-1:0] rd_addr,
  output logic          pe_clear,
  output logic          pe_en,
  output logic [N-1:0]  row_valid,
  output logic          done
);

  import systolic_seq_pkg::*;

  localparam int CW    = cnt_width(N, KW);
  localparam int DRAIN = drain_of(N);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [KW-1:0] klen_q;
  logic [KW-1:0] rd_addr_q;
  logic [CW-1:0] last_step;
  logic          run_go;
  logic          rd_go;
  logic          accept;

  // Steps are numbered from 0, so the final array step is klen + drain - 1;
  // the DONE cycle that follows is when every accumulator is settled.
  assign last_step = CW'(klen_q) + CW'(DRAIN) - CW'(1);
  assign run_go    = (state_q == ST_RUN) && !stall;
  assign rd_go     = run_go && (cnt_q < CW'(klen_q));
  assign accept    = (state_q == ST_IDLE) && start && (k_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      klen_q    <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) klen_q <= k_len;
      if (state_q == ST_CLEAR) cnt_q <= '0;
      else if (run_go)         cnt_q <= cnt_q + CW'(1);
      if (rd_go) rd_addr_q <= cnt_q[KW-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    pe_clear = 1'b0;
    pe_en    = 1'b0;
    a_rd_en  = 1'b0;
    b_rd_en  = 1'b0;
    done     = 1'b0;
    // Address follows the counter while reading, otherwise holds the last read.
    rd_addr  = rd_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        pe_clear = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        pe_en   = run_go;
        a_rd_en = rd_go;
        b_rd_en = rd_go;
        if (rd_go) rd_addr = cnt_q[KW-1:0];
        if (run_go && (cnt_q == last_step)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  skew_mask_gen #(
    .N  (N),
    .KW (KW),
    .CW (CW)
  ) u_skew (
    .cnt       (cnt_q),
    .klen      (klen_q),
    .run_en    (run_go),
    .row_valid (row_valid)
  );

endmodule
